// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifetch_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [XLEN_DEFAULT-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_fifo.sv
// Registered show-ahead FIFO; flush empties it and takes priority over push.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_eff;
  logic             pop_eff;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign push_eff = push && !full;
  assign pop_eff  = pop && !empty;
  assign rdata    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_eff) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_eff) - CW'(pop_eff);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch front end: owns the fetch PC, issues one word read at a time and
// buffers {pc, instr} pairs for decode; redirects flush and drop stale data.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  input  logic            if_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic            stale;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_cur;
  logic [XLEN-1:0] pc_plus4;
  logic            push;
  logic            pop;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   count_next;
  logic            fifo_full;
  logic            fifo_empty;
  logic            room;
  logic [2*XLEN-1:0] head;

  assign target   = redirect_pc & ~XLEN'(3);
  assign pc_cur   = redirect_valid ? target : fetch_pc;
  assign pc_plus4 = fetch_pc + XLEN'(4);
  assign push     = (state == WAIT) && imem_rvalid && !redirect_valid && !fifo_full;
  assign pop      = if_valid && if_ready;

  // Occupancy after this cycle's push/pop/flush decides whether a new request may go out.
  assign count_next = redirect_valid ? '0 : (fifo_count + CW'(push) - CW'(pop));
  assign room       = (count_next < DEPTH_C);

  assign if_valid = !fifo_empty;
  assign if_pc    = head[2*XLEN-1:XLEN];
  assign if_instr = head[XLEN-1:0];

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({fetch_pc, imem_rdata}),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A redirect during an ungranted request keeps the old address on the bus
  // and marks the eventual response as stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      stale     <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      if (redirect_valid) fetch_pc <= target;
      unique case (state)
        IDLE: begin
          if (redirect_valid || room) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc_cur;
          end
        end
        REQ: begin
          if (imem_gnt) begin
            state    <= (redirect_valid || stale) ? DROP : WAIT;
            stale    <= 1'b0;
            imem_req <= 1'b0;
          end else if (redirect_valid) begin
            stale <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (!redirect_valid) fetch_pc <= pc_plus4;
            if (redirect_valid || room) begin
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= redirect_valid ? target : pc_plus4;
            end else begin
              state <= IDLE;
            end
          end else if (redirect_valid) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            if (redirect_valid || room) begin
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= pc_cur;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed, table-driven bench for ifetch_unit: one record per clock cycle.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] redir_pc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        chkd;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  localparam logic [31:0] IA = 32'h0010_0093;
  localparam logic [31:0] IB = 32'h0020_0113;
  localparam logic [31:0] IC = 32'h0030_0193;
  localparam logic [31:0] ID = 32'h0040_0213;
  localparam logic [31:0] IE = 32'h0050_0293;
  localparam logic [31:0] IF = INSTR_NOP;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t main_tab[$];
  vec_t corner_tab[$];

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready)
  );

  function automatic vec_t mk(logic rst, logic redir, logic [31:0] rpc, logic gnt, logic rv,
                              logic [31:0] rd, logic rdy, logic ereq, logic [31:0] eaddr,
                              logic ev, logic chkd, logic [31:0] epc, logic [31:0] einstr);
    vec_t v;
    v.rst = rst; v.redir = redir; v.redir_pc = rpc; v.gnt = gnt; v.rvalid = rv;
    v.rdata = rd; v.rdy = rdy; v.e_req = ereq; v.e_addr = eaddr; v.e_valid = ev;
    v.chkd = chkd; v.e_pc = epc; v.e_instr = einstr;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset          = v.rst;
    redirect_valid = v.redir;
    redirect_pc    = v.redir_pc;
    imem_gnt       = v.gnt;
    imem_rvalid    = v.rvalid;
    imem_rdata     = v.rdata;
    if_ready       = v.rdy;
  endtask

  task automatic compare(input string name, input string tag, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s[%0d] %s: got %h expected %h", tag, idx, name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int idx, input vec_t v);
    compare("imem_req", tag, idx, {31'b0, imem_req}, {31'b0, v.e_req});
    compare("imem_addr", tag, idx, imem_addr, v.e_addr);
    compare("if_valid", tag, idx, {31'b0, if_valid}, {31'b0, v.e_valid});
    if (v.chkd) begin
      compare("if_pc", tag, idx, if_pc, v.e_pc);
      compare("if_instr", tag, idx, if_instr, v.e_instr);
    end
  endtask

  initial begin
    // Fields: rst redir rpc gnt rvalid rdata rdy | req addr valid chkd pc instr
    // Steady fetch with immediate grant and one-cycle response.
    main_tab.push_back(mk(0,0,0,0,0,0 ,1, 0,32'h0,0,1,32'h0,32'h0));
    main_tab.push_back(mk(0,0,0,1,0,0 ,1, 1,32'h0,0,0,0,0));
    main_tab.push_back(mk(0,0,0,0,1,IA,1, 0,32'h0,0,0,0,0));
    main_tab.push_back(mk(0,0,0,1,0,0 ,1, 1,32'h4,1,1,32'h0,IA));
    main_tab.push_back(mk(0,0,0,0,1,IB,1, 0,32'h4,0,0,0,0));
    main_tab.push_back(mk(0,0,0,1,0,0 ,1, 1,32'h8,1,1,32'h4,IB));
    main_tab.push_back(mk(0,0,0,0,1,IC,1, 0,32'h8,0,0,0,0));
    main_tab.push_back(mk(0,0,0,0,0,0 ,0, 1,32'hC,1,1,32'h8,IC));
    main_tab.push_back(mk(1,0,0,0,0,0 ,0, 1,32'hC,1,1,32'h8,IC));
    // Decode stalled: two entries fill the buffer, requests stop, then resume at 8.
    main_tab.push_back(mk(0,0,0,0,0,0 ,0, 0,32'h0,0,1,32'h0,32'h0));
    main_tab.push_back(mk(0,0,0,1,0,0 ,0, 1,32'h0,0,0,0,0));
    main_tab.push_back(mk(0,0,0,0,1,IA,0, 0,32'h0,0,0,0,0));
    main_tab.push_back(mk(0,0,0,1,0,0 ,0, 1,32'h4,1,1,32'h0,IA));
    main_tab.push_back(mk(0,0,0,0,1,IB,0, 0,32'h4,1,1,32'h0,IA));
    main_tab.push_back(mk(0,0,0,1,0,0 ,0, 0,32'h4,1,1,32'h0,IA));
    main_tab.push_back(mk(0,0,0,1,0,0 ,0, 0,32'h4,1,1,32'h0,IA));
    main_tab.push_back(mk(0,0,0,1,0,0 ,0, 0,32'h4,1,1,32'h0,IA));
    main_tab.push_back(mk(0,0,0,0,0,0 ,1, 0,32'h4,1,1,32'h0,IA));
    main_tab.push_back(mk(0,0,0,0,0,0 ,1, 1,32'h8,1,1,32'h4,IB));
    main_tab.push_back(mk(0,0,0,1,0,0 ,1, 1,32'h8,0,0,0,0));
    main_tab.push_back(mk(0,0,0,0,1,IC,1, 0,32'h8,0,0,0,0));
    main_tab.push_back(mk(0,0,0,0,0,0 ,1, 1,32'hC,1,1,32'h8,IC));
    main_tab.push_back(mk(1,0,0,0,0,0 ,0, 1,32'hC,0,0,0,0));
    // Redirect while waiting on address 4: buffer flushed, response dropped.
    main_tab.push_back(mk(0,0,0,0,0,0 ,0, 0,32'h0,0,1,32'h0,32'h0));
    main_tab.push_back(mk(0,0,0,1,0,0 ,0, 1,32'h0,0,0,0,0));
    main_tab.push_back(mk(0,0,0,0,1,IA,0, 0,32'h0,0,0,0,0));
    main_tab.push_back(mk(0,0,0,1,0,0 ,0, 1,32'h4,1,1,32'h0,IA));
    main_tab.push_back(mk(0,1,32'h102,0,0,0,0, 0,32'h4,1,1,32'h0,IA));
    main_tab.push_back(mk(0,0,0,0,1,IB,0, 0,32'h4,0,0,0,0));
    main_tab.push_back(mk(0,0,0,1,0,0 ,0, 1,32'h100,0,0,0,0));
    main_tab.push_back(mk(0,0,0,0,1,IC,0, 0,32'h100,0,0,0,0));
    main_tab.push_back(mk(0,0,0,0,0,0 ,1, 1,32'h104,1,1,32'h100,IC));
    // Redirect coinciding with the response: stale data never reaches decode.
    main_tab.push_back(mk(0,0,0,1,0,0 ,1, 1,32'h104,0,0,0,0));
    main_tab.push_back(mk(0,1,32'h200,0,1,ID,1, 0,32'h104,0,0,0,0));
    main_tab.push_back(mk(0,0,0,0,0,0 ,1, 1,32'h200,0,0,0,0));
    main_tab.push_back(mk(1,0,0,0,0,0 ,0, 1,32'h200,0,0,0,0));

    // Redirect with grant withheld, address wrap, reset during WAIT.
    corner_tab.push_back(mk(0,0,0,0,0,0 ,0, 0,32'h0,0,1,32'h0,32'h0));
    corner_tab.push_back(mk(0,0,0,1,0,0 ,0, 1,32'h0,0,0,0,0));
    corner_tab.push_back(mk(0,0,0,0,1,IA,0, 0,32'h0,0,0,0,0));
    corner_tab.push_back(mk(0,1,32'h300,0,0,0,0, 1,32'h4,1,1,32'h0,IA));
    corner_tab.push_back(mk(0,0,0,0,0,0 ,0, 1,32'h4,0,0,0,0));
    corner_tab.push_back(mk(0,0,0,0,0,0 ,0, 1,32'h4,0,0,0,0));
    corner_tab.push_back(mk(0,0,0,1,0,0 ,0, 1,32'h4,0,0,0,0));
    corner_tab.push_back(mk(0,0,0,0,1,IB,0, 0,32'h4,0,0,0,0));
    corner_tab.push_back(mk(0,0,0,1,0,0 ,0, 1,32'h300,0,0,0,0));
    corner_tab.push_back(mk(0,0,0,0,1,IC,0, 0,32'h300,0,0,0,0));
    corner_tab.push_back(mk(0,1,32'hFFFF_FFFF,1,0,0,0, 1,32'h304,1,1,32'h300,IC));
    corner_tab.push_back(mk(0,0,0,0,1,ID,0, 0,32'h304,0,0,0,0));
    corner_tab.push_back(mk(0,0,0,1,0,0 ,0, 1,32'hFFFF_FFFC,0,0,0,0));
    corner_tab.push_back(mk(0,0,0,0,1,IE,0, 0,32'hFFFF_FFFC,0,0,0,0));
    corner_tab.push_back(mk(0,0,0,1,0,0 ,1, 1,32'h0,1,1,32'hFFFF_FFFC,IE));
    corner_tab.push_back(mk(1,0,0,0,0,0 ,0, 0,32'h0,0,0,0,0));
    corner_tab.push_back(mk(0,0,0,0,1,ID,0, 0,32'h0,0,1,32'h0,32'h0));
    corner_tab.push_back(mk(0,0,0,1,0,0 ,0, 1,32'h0,0,0,0,0));
    corner_tab.push_back(mk(0,0,0,0,1,IF,0, 0,32'h0,0,0,0,0));
    corner_tab.push_back(mk(0,0,0,0,0,0 ,0, 1,32'h4,1,1,32'h0,IF));

    applyStimulus(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < main_tab.size(); i++) begin
      applyStimulus(main_tab[i]);
      checkOutput("main", i, main_tab[i]);
      @(negedge clk);
    end
    for (int i = 0; i < corner_tab.size(); i++) begin
      applyStimulus(corner_tab[i]);
      checkOutput("corner", i, corner_tab[i]);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
